pe_net_iface: RTL and testbench
===============================

// Module: pe_net_iface
// PURPOSE
//  Leaf network interface between one processing element (PE) and a leaf port of the binary-tree NoC switch.
//  TX: header prepended to PE payload, buffered in a FIFO, streamed to the switch. RX: switch packets
//  address-checked, header stripped, delivered to the PE via a 2-entry skid buffer. Saturating traffic counters.
// PARAMETERS
//  DataWidth  36  NoC flit width (header + payload)
//  AddrWidth  4   node address width; dest = flit[DataWidth-1 -: AddrWidth], src = next AddrWidth bits below
//  MyAddr     0   this PE's node address
//  TxDepth    8   TX FIFO depth, power of two, >=2
//  CntWidth   16  status counter width
// PORTS
//  i_sclk          in   1                     clock
//  i_reset         in   1                     asynchronous reset, active-high
//  i_pe_data       in   DataWidth-2*AddrWidth TX payload from PE
//  i_pe_dest       in   AddrWidth             TX destination address
//  i_pe_valid      in   1                     TX payload valid
//  o_pe_ready      out  1                     TX FIFO can accept
//  o_data          out  DataWidth             flit to switch
//  o_data_valid    out  1                     flit valid
//  i_data_ready    in   1                     switch accepts flit
//  i_data          in   DataWidth             flit from switch
//  i_data_valid    in   1                     flit valid
//  o_data_ready    out  1                     interface accepts flit
//  o_pe_rx_data    out  DataWidth-2*AddrWidth RX payload to PE
//  o_pe_rx_src     out  AddrWidth             RX source address
//  o_pe_rx_valid   out  1                     RX payload valid
//  i_pe_rx_ready   in   1                     PE accepts RX payload
//  o_tx_count      out  CntWidth              flits sent to switch
//  o_rx_count      out  CntWidth              flits delivered to PE
//  o_drop_count    out  CntWidth              misaddressed flits dropped
// BEHAVIOUR
//  Reset (async, while i_reset=1): FIFO and skid buffer empty; o_data_valid=0, o_pe_rx_valid=0, o_pe_ready=0,
//   o_data_ready=0, all counters 0; o_data/o_pe_rx_* = 0. Ready outputs go to 1 first rising edge after release.
//  Handshakes: valid/ready; transfer on a rising edge with valid&ready. Outputs hold valid and data stable
//   until accepted; never deassert valid before acceptance.
//  TX: flit = {i_pe_dest, MyAddr, i_pe_data}. o_pe_ready = !full (registered occupancy; no write-through
//   when full even if a read occurs the same cycle). Write at edge N -> o_data_valid=1 after edge N
//   (1-cycle latency). Simultaneous read+write: occupancy unchanged, order preserved. Pointers wrap mod TxDepth.
//   Self-addressed (dest==MyAddr) flits are sent normally.
//  RX: o_data_ready = skid buffer has a free entry (registered). Accepted flit with dest==MyAddr enters skid
//   buffer, visible on o_pe_rx_* one cycle later; dest!=MyAddr discarded, o_drop_count += 1, never reaches PE.
//   Full throughput: one flit/cycle sustained while i_pe_rx_ready=1. When PE stalls, the 2nd entry absorbs
//   the in-flight flit; o_data_ready falls the cycle after the buffer becomes full.
//  Counters: +1 per accepted transfer on the respective interface; saturate at 2^CntWidth-1, never wrap.
//  Reset mid-packet: all stored flits lost; counters cleared; no partial flit emitted after release.
// TESTING
//  1 MyAddr=2: PE sends dest=5, payload 0x1234, switch ready -> o_data=={4'h5,4'h2,28'h1234} next cycle; tx_count=1.
//  2 i_data_ready=0, PE pushes 9 flits -> o_pe_ready=0 after 8th; 9th held; release ready -> 8 flits out in order.
//  3 switch sends dest=2,src=7,payload 0xABC -> o_pe_rx_valid, src=7, data=0xABC; rx_count=1.
//  4 switch sends dest=3 -> no PE output, o_drop_count=1, o_data_ready stays 1.
//  5 i_pe_rx_ready=0, stream 3 valid flits -> 2 accepted, o_data_ready=0; ready=1 -> all 3 delivered in order.
//  6 assert i_reset with 4 flits in TX FIFO -> o_data_valid=0 immediately; counters 0; no stale flit after release.

Source files
------------

// File: rtl/pe_net_iface_if.sv
// Handshake bundle between a PE leaf interface and its neighbours: PE TX/RX streams and switch flit streams.
// The slave modport is the network interface itself; the master modport is whoever drives it.
interface pe_net_iface_if #(
  parameter int unsigned DataWidth = 36,
  parameter int unsigned AddrWidth = 4
);
  localparam int unsigned PayWidth = DataWidth - 2 * AddrWidth;

  logic [PayWidth-1:0]  i_pe_data;
  logic [AddrWidth-1:0] i_pe_dest;
  logic                 i_pe_valid;
  logic                 o_pe_ready;

  logic [DataWidth-1:0] o_data;
  logic                 o_data_valid;
  logic                 i_data_ready;

  logic [DataWidth-1:0] i_data;
  logic                 i_data_valid;
  logic                 o_data_ready;

  logic [PayWidth-1:0]  o_pe_rx_data;
  logic [AddrWidth-1:0] o_pe_rx_src;
  logic                 o_pe_rx_valid;
  logic                 i_pe_rx_ready;

  modport master (
    output i_pe_data, i_pe_dest, i_pe_valid, i_data_ready, i_data, i_data_valid, i_pe_rx_ready,
    input  o_pe_ready, o_data, o_data_valid, o_data_ready, o_pe_rx_data, o_pe_rx_src, o_pe_rx_valid
  );

  modport slave (
    input  i_pe_data, i_pe_dest, i_pe_valid, i_data_ready, i_data, i_data_valid, i_pe_rx_ready,
    output o_pe_ready, o_data, o_data_valid, o_data_ready, o_pe_rx_data, o_pe_rx_src, o_pe_rx_valid
  );
endinterface

// File: rtl/pe_net_iface.sv
// Leaf NoC network interface: TX header insertion + FIFO toward the switch, RX address filter + 2-entry
// skid buffer toward the PE, and saturating traffic counters.
module pe_net_iface #(
  parameter int unsigned DataWidth = 36,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned MyAddr    = 0,
  parameter int unsigned TxDepth   = 8,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                i_sclk,
  input  logic                i_reset,
  pe_net_iface_if.slave       bus,
  output logic [CntWidth-1:0] o_tx_count,
  output logic [CntWidth-1:0] o_rx_count,
  output logic [CntWidth-1:0] o_drop_count
);

  localparam int unsigned PayWidth = DataWidth - 2 * AddrWidth;
  localparam int unsigned PtrWidth = $clog2(TxDepth);
  localparam int unsigned OccWidth = PtrWidth + 1;
  localparam logic [AddrWidth-1:0] MyAddrL  = AddrWidth'(MyAddr);
  localparam logic [OccWidth-1:0]  TxFull   = OccWidth'(TxDepth);

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CntWidth'(1) : v;
  endfunction

  // ---------------- TX path ----------------
  logic [DataWidth-1:0] tx_mem [TxDepth];
  logic [PtrWidth-1:0]  tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PtrWidth-1:0]  tx_rd_ptr_q, tx_rd_ptr_d;
  logic [OccWidth-1:0]  tx_occ_q, tx_occ_d, tx_remain;
  logic [DataWidth-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 pe_ready_q, pe_ready_d;
  logic                 tx_wr, tx_rd;
  logic [DataWidth-1:0] tx_flit;

  assign tx_flit = {bus.i_pe_dest, MyAddrL, bus.i_pe_data};
  assign tx_wr   = bus.i_pe_valid & pe_ready_q;
  assign tx_rd   = tx_valid_q & bus.i_data_ready;

  // Output register always shows the FIFO head; an empty FIFO lets a fresh write land straight in it.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + PtrWidth'(tx_wr);
    tx_rd_ptr_d = tx_rd_ptr_q + PtrWidth'(tx_rd);
    tx_occ_d    = tx_occ_q + OccWidth'(tx_wr) - OccWidth'(tx_rd);
    tx_remain   = tx_occ_q - OccWidth'(tx_rd);
    tx_data_d   = tx_data_q;
    if (tx_remain == '0) begin
      if (tx_wr) tx_data_d = tx_flit;
    end else begin
      tx_data_d = tx_mem[tx_rd_ptr_d];
    end
    tx_valid_d = (tx_occ_d != '0);
    pe_ready_d = (tx_occ_d != TxFull);
  end

  always_ff @(posedge i_sclk) begin
    if (tx_wr) tx_mem[tx_wr_ptr_q] <= tx_flit;
  end

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_occ_q    <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      pe_ready_q  <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_occ_q    <= tx_occ_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      pe_ready_q  <= pe_ready_d;
    end
  end

  assign bus.o_data       = tx_data_q;
  assign bus.o_data_valid = tx_valid_q;
  assign bus.o_pe_ready   = pe_ready_q;

  // ---------------- RX path ----------------
  logic [AddrWidth-1:0] rx_dest, rx_src;
  logic [PayWidth-1:0]  rx_pay;
  logic                 rx_acc, rx_push, rx_drop, rx_pop;
  logic [1:0]           rx_occ_q, rx_occ_d;
  logic [PayWidth-1:0]  rx_head_data_q, rx_head_data_d, rx_spare_data_q, rx_spare_data_d;
  logic [AddrWidth-1:0] rx_head_src_q, rx_head_src_d, rx_spare_src_q, rx_spare_src_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ready_q, rx_ready_d;

  assign rx_dest = bus.i_data[DataWidth-1 -: AddrWidth];
  assign rx_src  = bus.i_data[DataWidth-AddrWidth-1 -: AddrWidth];
  assign rx_pay  = bus.i_data[PayWidth-1:0];
  assign rx_acc  = bus.i_data_valid & rx_ready_q;
  assign rx_push = rx_acc & (rx_dest == MyAddrL);
  assign rx_drop = rx_acc & (rx_dest != MyAddrL);
  assign rx_pop  = rx_valid_q & bus.i_pe_rx_ready;

  // Head entry drives the PE directly; the spare entry only fills while the PE is stalled.
  always_comb begin
    rx_head_data_d  = rx_head_data_q;
    rx_head_src_d   = rx_head_src_q;
    rx_spare_data_d = rx_spare_data_q;
    rx_spare_src_d  = rx_spare_src_q;
    rx_occ_d        = rx_occ_q + 2'(rx_push) - 2'(rx_pop);
    if (rx_pop) begin
      if (rx_occ_q == 2'd2) begin
        rx_head_data_d = rx_spare_data_q;
        rx_head_src_d  = rx_spare_src_q;
      end else if (rx_push) begin
        rx_head_data_d = rx_pay;
        rx_head_src_d  = rx_src;
      end
    end else if (rx_push) begin
      if (rx_occ_q == 2'd0) begin
        rx_head_data_d = rx_pay;
        rx_head_src_d  = rx_src;
      end else begin
        rx_spare_data_d = rx_pay;
        rx_spare_src_d  = rx_src;
      end
    end
    rx_valid_d = (rx_occ_d != 2'd0);
    rx_ready_d = (rx_occ_d != 2'd2);
  end

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      rx_occ_q        <= 2'd0;
      rx_head_data_q  <= '0;
      rx_head_src_q   <= '0;
      rx_spare_data_q <= '0;
      rx_spare_src_q  <= '0;
      rx_valid_q      <= 1'b0;
      rx_ready_q      <= 1'b0;
    end else begin
      rx_occ_q        <= rx_occ_d;
      rx_head_data_q  <= rx_head_data_d;
      rx_head_src_q   <= rx_head_src_d;
      rx_spare_data_q <= rx_spare_data_d;
      rx_spare_src_q  <= rx_spare_src_d;
      rx_valid_q      <= rx_valid_d;
      rx_ready_q      <= rx_ready_d;
    end
  end

  assign bus.o_pe_rx_data  = rx_head_data_q;
  assign bus.o_pe_rx_src   = rx_head_src_q;
  assign bus.o_pe_rx_valid = rx_valid_q;
  assign bus.o_data_ready  = rx_ready_q;

  // ---------------- Counters ----------------
  logic [CntWidth-1:0] tx_cnt_q, rx_cnt_q, drop_cnt_q;

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q   <= sat_inc(tx_cnt_q, tx_rd);
      rx_cnt_q   <= sat_inc(rx_cnt_q, rx_pop);
      drop_cnt_q <= sat_inc(drop_cnt_q, rx_drop);
    end
  end

  assign o_tx_count   = tx_cnt_q;
  assign o_rx_count   = rx_cnt_q;
  assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_pe_net_iface.sv
// Directed bench for pe_net_iface (MyAddr=2, 4-bit counters so saturation is reachable).
module tb_pe_net_iface;
  localparam int unsigned DW = 36;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] tx_count, rx_count, drop_count;

  pe_net_iface_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

  pe_net_iface #(.DataWidth(DW), .AddrWidth(AW), .MyAddr(2), .TxDepth(8), .CntWidth(CW)) dut (
    .i_sclk(clk), .i_reset(rst), .bus(bus),
    .o_tx_count(tx_count), .o_rx_count(rx_count), .o_drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] exp_tx [9];
  logic [27:0]   exp_rx [3];
  logic          acc;
  int            idx;

  initial begin
    bus.i_pe_data = '0; bus.i_pe_dest = '0; bus.i_pe_valid = 0;
    bus.i_data_ready = 0; bus.i_data = '0; bus.i_data_valid = 0; bus.i_pe_rx_ready = 0;
    tick(); tick();
    check_eq("rst_pe_ready", 64'(bus.o_pe_ready), 0);
    check_eq("rst_data_ready", 64'(bus.o_data_ready), 0);
    check_eq("rst_data_valid", 64'(bus.o_data_valid), 0);
    check_eq("rst_tx_count", 64'(tx_count), 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_pe_ready", 64'(bus.o_pe_ready), 1);
    check_eq("post_rst_data_ready", 64'(bus.o_data_ready), 1);

    // 1: single TX flit with header prepended
    bus.i_pe_data = 28'h1234; bus.i_pe_dest = 4'h5; bus.i_pe_valid = 1;
    tick();
    bus.i_pe_valid = 0;
    check_eq("t1_valid", 64'(bus.o_data_valid), 1);
    check_eq("t1_data", 64'(bus.o_data), 64'h5_2_0001234);
    bus.i_data_ready = 1;
    tick();
    bus.i_data_ready = 0;
    check_eq("t1_tx_count", 64'(tx_count), 1);
    check_eq("t1_empty", 64'(bus.o_data_valid), 0);

    // 2: fill the FIFO while the switch stalls, then drain in order
    for (int k = 0; k < 9; k++) exp_tx[k] = {4'(k), 4'h2, 28'(32'h100 + k)};
    for (int k = 0; k < 8; k++) begin
      bus.i_pe_data = 28'(32'h100 + k); bus.i_pe_dest = 4'(k); bus.i_pe_valid = 1;
      tick();
    end
    check_eq("t2_full_ready", 64'(bus.o_pe_ready), 0);
    bus.i_pe_data = 28'h108; bus.i_pe_dest = 4'h8;
    tick(); tick();
    check_eq("t2_still_full", 64'(bus.o_pe_ready), 0);
    check_eq("t2_head_held", 64'(bus.o_data), 64'(exp_tx[0]));
    bus.i_data_ready = 1;
    for (int j = 0; j < 9; j++) begin
      check_eq($sformatf("t2_valid%0d", j), 64'(bus.o_data_valid), 1);
      check_eq($sformatf("t2_data%0d", j), 64'(bus.o_data), 64'(exp_tx[j]));
      acc = bus.i_pe_valid & bus.o_pe_ready;
      tick();
      if (acc) bus.i_pe_valid = 0;
    end
    check_eq("t2_drained", 64'(bus.o_data_valid), 0);
    check_eq("t2_tx_count", 64'(tx_count), 10);
    bus.i_data_ready = 0;

    // 3: addressed RX flit delivered with header stripped
    bus.i_data = {4'h2, 4'h7, 28'hABC}; bus.i_data_valid = 1;
    tick();
    bus.i_data_valid = 0;
    check_eq("t3_rx_valid", 64'(bus.o_pe_rx_valid), 1);
    check_eq("t3_rx_src", 64'(bus.o_pe_rx_src), 7);
    check_eq("t3_rx_data", 64'(bus.o_pe_rx_data), 64'hABC);
    bus.i_pe_rx_ready = 1;
    tick();
    bus.i_pe_rx_ready = 0;
    check_eq("t3_rx_count", 64'(rx_count), 1);
    check_eq("t3_rx_empty", 64'(bus.o_pe_rx_valid), 0);

    // 4: misaddressed flit dropped
    bus.i_data = {4'h3, 4'h7, 28'h55}; bus.i_data_valid = 1;
    tick();
    bus.i_data_valid = 0;
    check_eq("t4_drop_count", 64'(drop_count), 1);
    check_eq("t4_no_rx", 64'(bus.o_pe_rx_valid), 0);
    check_eq("t4_ready", 64'(bus.o_data_ready), 1);

    // 5: PE stall fills the skid buffer, then releases in order
    for (int k = 0; k < 3; k++) exp_rx[k] = 28'(32'h10 + k);
    bus.i_data = {4'h2, 4'h1, exp_rx[0]}; bus.i_data_valid = 1;
    tick();
    bus.i_data = {4'h2, 4'h2, exp_rx[1]};
    tick();
    check_eq("t5_ready_low", 64'(bus.o_data_ready), 0);
    bus.i_data = {4'h2, 4'h3, exp_rx[2]};
    tick();
    check_eq("t5_ready_held", 64'(bus.o_data_ready), 0);
    check_eq("t5_head", 64'(bus.o_pe_rx_data), 64'(exp_rx[0]));
    bus.i_pe_rx_ready = 1;
    idx = 0;
    for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
      if (bus.o_pe_rx_valid) begin
        check_eq($sformatf("t5_data%0d", idx), 64'(bus.o_pe_rx_data), 64'(exp_rx[idx]));
        check_eq($sformatf("t5_src%0d", idx), 64'(bus.o_pe_rx_src), 64'(idx + 1));
        idx++;
      end
      acc = bus.i_data_valid & bus.o_data_ready;
      tick();
      if (acc) bus.i_data_valid = 0;
    end
    check_eq("t5_delivered", 64'(idx), 3);
    check_eq("t5_rx_count", 64'(rx_count), 4);
    bus.i_pe_rx_ready = 0;

    // self-addressed TX goes out normally
    bus.i_pe_data = 28'h77; bus.i_pe_dest = 4'h2; bus.i_pe_valid = 1;
    tick();
    bus.i_pe_valid = 0;
    check_eq("self_tx", 64'(bus.o_data), 64'h2_2_0000077);

    // 6: reset with flits queued
    for (int k = 0; k < 3; k++) begin
      bus.i_pe_data = 28'(32'h200 + k); bus.i_pe_dest = 4'h4; bus.i_pe_valid = 1;
      tick();
    end
    bus.i_pe_valid = 0;
    rst = 1'b1;
    #1;
    check_eq("t6_valid_async", 64'(bus.o_data_valid), 0);
    check_eq("t6_tx_count", 64'(tx_count), 0);
    check_eq("t6_rx_count", 64'(rx_count), 0);
    check_eq("t6_drop_count", 64'(drop_count), 0);
    tick();
    rst = 1'b0;
    bus.i_data_ready = 1;
    tick(); tick(); tick();
    check_eq("t6_no_stale", 64'(bus.o_data_valid), 0);
    check_eq("t6_tx_after", 64'(tx_count), 0);

    // counter saturation with 20 dropped flits
    bus.i_data = {4'h9, 4'h1, 28'h1}; bus.i_data_valid = 1;
    for (int k = 0; k < 20; k++) tick();
    bus.i_data_valid = 0;
    check_eq("sat_drop", 64'(drop_count), 15);
    check_eq("sat_no_rx", 64'(bus.o_pe_rx_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
